// File: rtl/price_buffer_writer.sv
// Filters top-of-book updates (invalid / duplicate) and emits one history write per accepted quote.
// Latency: 1 cycle from i_valid to o_valid / o_drop_*; all outputs registered.
// Backpressure: none; at most one update per cycle, consumer must accept every write.
module price_buffer_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFFER_SIZE = 20,
  parameter int NUM_STOCKS  = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]                   i_best_ask,
  input  logic [DATA_WIDTH-1:0]                   i_best_bid,
  input  logic [$clog2(NUM_STOCKS)-1:0]           i_stock_id,
  input  logic                                    i_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_write_address,
  output logic [DATA_WIDTH-1:0]                   o_best_ask,
  output logic [DATA_WIDTH-1:0]                   o_best_bid,
  output logic [$clog2(NUM_STOCKS)-1:0]           o_stock_id,
  output logic                                    o_valid,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]        o_fill_count,
  output logic                                    o_warm,
  output logic                                    o_drop_invalid,
  output logic                                    o_drop_dup
);

  localparam int SW = $clog2(NUM_STOCKS);
  localparam int AW = $clog2(NUM_STOCKS*BUFFER_SIZE);
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int FW = $clog2(BUFFER_SIZE+1);
  localparam logic [SW:0] NUM_STOCKS_W = NUM_STOCKS[SW:0];

  // Per-stock history state
  logic [PW-1:0]         wr_ptr   [NUM_STOCKS];
  logic [FW-1:0]         fill     [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] seen;

  // Constant base-address table, so no multiplier sits in the address path
  logic [AW-1:0] base_lut [NUM_STOCKS];
  for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_base
    assign base_lut[g] = AW'(g * BUFFER_SIZE);
  end

  logic          bad_id;
  logic          is_invalid;
  logic          is_dup;
  logic          accept;
  logic [PW-1:0] ptr_cur;
  logic [PW-1:0] ptr_nxt;
  logic [FW-1:0] fill_nxt;
  logic [AW-1:0] addr_nxt;

  // Classify the incoming update and compute the next per-stock pointer / count
  always_comb begin
    bad_id     = ({1'b0, i_stock_id} >= NUM_STOCKS_W);
    is_invalid = 1'b0;
    is_dup     = 1'b0;
    accept     = 1'b0;
    ptr_cur    = '0;
    ptr_nxt    = '0;
    fill_nxt   = '0;
    addr_nxt   = '0;
    if (i_valid) begin
      if (bad_id || (i_best_bid == '0) || (i_best_ask == '0) || (i_best_ask < i_best_bid)) begin
        is_invalid = 1'b1;
      end else if (seen[i_stock_id] && (i_best_bid == last_bid[i_stock_id]) &&
                   (i_best_ask == last_ask[i_stock_id])) begin
        is_dup = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end
    if (!bad_id) begin
      ptr_cur  = wr_ptr[i_stock_id];
      ptr_nxt  = (ptr_cur == PW'(BUFFER_SIZE-1)) ? '0 : ptr_cur + 1'b1;
      fill_nxt = (fill[i_stock_id] == FW'(BUFFER_SIZE)) ? fill[i_stock_id]
                                                         : fill[i_stock_id] + 1'b1;
      addr_nxt = base_lut[i_stock_id] + AW'(ptr_cur);
    end
  end

  // Per-stock state update on accept; reset wins over a same-cycle update
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        wr_ptr[s]   <= '0;
        fill[s]     <= '0;
        last_bid[s] <= '0;
        last_ask[s] <= '0;
      end
      seen <= '0;
    end else if (accept) begin
      wr_ptr[i_stock_id]   <= ptr_nxt;
      fill[i_stock_id]     <= fill_nxt;
      last_bid[i_stock_id] <= i_best_bid;
      last_ask[i_stock_id] <= i_best_ask;
      seen[i_stock_id]     <= 1'b1;
    end
  end

  // Registered outputs: write fields hold on drops, strobes pulse for one cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_write_address <= '0;
      o_best_ask      <= '0;
      o_best_bid      <= '0;
      o_stock_id      <= '0;
      o_valid         <= 1'b0;
      o_fill_count    <= '0;
      o_warm          <= 1'b0;
      o_drop_invalid  <= 1'b0;
      o_drop_dup      <= 1'b0;
    end else begin
      o_valid        <= accept;
      o_drop_invalid <= is_invalid;
      o_drop_dup     <= is_dup;
      if (accept) begin
        o_write_address <= addr_nxt;
        o_best_ask      <= i_best_ask;
        o_best_bid      <= i_best_bid;
        o_stock_id      <= i_stock_id;
        o_fill_count    <= fill_nxt;
        o_warm          <= (fill_nxt == FW'(BUFFER_SIZE));
      end
    end
  end

endmodule

// File: tb/tb_price_buffer_writer.sv
// Directed bench for price_buffer_writer with a queue-based scoreboard.
// Each step drives one cycle of input, pushes the expected outputs, then pops and compares.
// Expected values come from a small per-stock reference model plus fixed spot values.
module tb_price_buffer_writer;

  localparam int DW = 32;
  localparam int BS = 20;
  localparam int NS = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic [DW-1:0] i_best_ask;
  logic [DW-1:0] i_best_bid;
  logic [1:0]    i_stock_id;
  logic          i_valid;
  logic [6:0]    o_write_address;
  logic [DW-1:0] o_best_ask;
  logic [DW-1:0] o_best_bid;
  logic [1:0]    o_stock_id;
  logic          o_valid;
  logic [4:0]    o_fill_count;
  logic          o_warm;
  logic          o_drop_invalid;
  logic          o_drop_dup;

  price_buffer_writer #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(NS)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_best_ask(i_best_ask), .i_best_bid(i_best_bid),
    .i_stock_id(i_stock_id), .i_valid(i_valid), .o_write_address(o_write_address),
    .o_best_ask(o_best_ask), .o_best_bid(o_best_bid), .o_stock_id(o_stock_id),
    .o_valid(o_valid), .o_fill_count(o_fill_count), .o_warm(o_warm),
    .o_drop_invalid(o_drop_invalid), .o_drop_dup(o_drop_dup)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [6:0]    addr;
    logic [DW-1:0] ask;
    logic [DW-1:0] bid;
    logic [1:0]    id;
    logic          vld;
    logic [4:0]    fill;
    logic          warm;
    logic          dinv;
    logic          ddup;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   m_ptr  [NS];
  int   m_fill [NS];
  logic [DW-1:0] m_bid [NS];
  logic [DW-1:0] m_ask [NS];
  bit   m_seen [NS];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0; m_fill[s] = 0; m_bid[s] = '0; m_ask[s] = '0; m_seen[s] = 0;
    end
    prev = '0;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge
  task automatic step(input logic rst_n, input logic v, input logic [1:0] id,
                      input logic [DW-1:0] bid, input logic [DW-1:0] ask);
    exp_t e;
    exp_t got;
    i_reset_n  = rst_n;
    i_valid    = v;
    i_stock_id = id;
    i_best_bid = bid;
    i_best_ask = ask;
    e = prev;
    e.vld = 1'b0; e.dinv = 1'b0; e.ddup = 1'b0;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else if (v) begin
      if (bid == 0 || ask == 0 || ask < bid) begin
        e.dinv = 1'b1;
      end else if (m_seen[id] && m_bid[id] == bid && m_ask[id] == ask) begin
        e.ddup = 1'b1;
      end else begin
        if (m_fill[id] < BS) m_fill[id]++;
        e.addr = 7'(id * BS + m_ptr[id]);
        e.ask  = ask;
        e.bid  = bid;
        e.id   = id;
        e.vld  = 1'b1;
        e.fill = 5'(m_fill[id]);
        e.warm = (m_fill[id] == BS);
        m_ptr[id]  = (m_ptr[id] == BS - 1) ? 0 : m_ptr[id] + 1;
        m_bid[id]  = bid;
        m_ask[id]  = ask;
        m_seen[id] = 1;
        prev = e;
      end
    end
    q.push_back(e);
    @(posedge i_clk);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (q.size() > 0) begin
      got = q.pop_front();
      chk("addr", 64'(o_write_address), 64'(got.addr));
      chk("ask",  64'(o_best_ask),      64'(got.ask));
      chk("bid",  64'(o_best_bid),      64'(got.bid));
      chk("id",   64'(o_stock_id),      64'(got.id));
      chk("vld",  64'(o_valid),         64'(got.vld));
      chk("fill", 64'(o_fill_count),    64'(got.fill));
      chk("warm", 64'(o_warm),          64'(got.warm));
      chk("dinv", 64'(o_drop_invalid),  64'(got.dinv));
      chk("ddup", 64'(o_drop_dup),      64'(got.ddup));
      chk("onehot", 64'($countones({o_valid, o_drop_invalid, o_drop_dup}) <= 1), 64'(1));
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  initial begin
    model_reset();
    i_reset_n = 1'b0; i_valid = 1'b0; i_stock_id = '0; i_best_bid = '0; i_best_ask = '0;
    do_reset();
    do_reset();

    // 1: stock 0 fills its window and wraps
    for (int k = 0; k < 21; k++) begin
      step(1'b1, 1'b1, 2'd0, DW'(100 + k), DW'(101 + k));
      if (k == 18) chk("t1_warm_low_19", 64'(o_warm), 64'(0));
      if (k == 19) begin
        chk("t1_addr19", 64'(o_write_address), 64'(19));
        chk("t1_warm_20", 64'(o_warm), 64'(1));
      end
    end
    chk("t1_wrap_addr", 64'(o_write_address), 64'(0));
    chk("t1_fill_sat", 64'(o_fill_count), 64'(20));

    // 2: independent stocks use their own regions
    do_reset();
    step(1'b1, 1'b1, 2'd2, 32'd50, 32'd51);
    chk("t2_addr40", 64'(o_write_address), 64'(40));
    step(1'b1, 1'b1, 2'd3, 32'd70, 32'd72);
    chk("t2_addr60", 64'(o_write_address), 64'(60));
    chk("t2_fill1", 64'(o_fill_count), 64'(1));
    step(1'b1, 1'b1, 2'd0, 32'd5, 32'd6);
    chk("t2_s0_addr0", 64'(o_write_address), 64'(0));

    // 3: duplicate suppression, pointer not advanced by the dup
    step(1'b1, 1'b1, 2'd1, 32'd10, 32'd12);
    chk("t3_addr20", 64'(o_write_address), 64'(20));
    step(1'b1, 1'b1, 2'd1, 32'd10, 32'd12);
    chk("t3_dup", 64'(o_drop_dup), 64'(1));
    step(1'b1, 1'b0, 2'd1, 32'd0, 32'd0);
    step(1'b1, 1'b1, 2'd1, 32'd11, 32'd12);
    chk("t3_addr21", 64'(o_write_address), 64'(21));

    // 4: crossed and zero quotes dropped, locked quote accepted
    do_reset();
    step(1'b1, 1'b1, 2'd0, 32'd100, 32'd99);
    chk("t4_crossed", 64'(o_drop_invalid), 64'(1));
    step(1'b1, 1'b1, 2'd0, 32'd0, 32'd5);
    chk("t4_zero_bid", 64'(o_drop_invalid), 64'(1));
    step(1'b1, 1'b1, 2'd0, 32'd5, 32'd0);
    step(1'b1, 1'b1, 2'd0, 32'd7, 32'd7);
    chk("t4_locked_vld", 64'(o_valid), 64'(1));
    chk("t4_locked_addr", 64'(o_write_address), 64'(0));

    // 5: 25 back-to-back updates on one stock
    do_reset();
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b1, 2'd0, DW'(200 + k), DW'(205 + k));
      chk("t5_contig", 64'(o_write_address), 64'(k % 20));
    end

    // 6: reset with a same-cycle update drops it and clears dup history
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 2'd0, DW'(300 + k), DW'(310 + k));
    step(1'b0, 1'b1, 2'd0, 32'd400, 32'd410);
    chk("t6_rst_vld", 64'(o_valid), 64'(0));
    chk("t6_rst_addr", 64'(o_write_address), 64'(0));
    step(1'b1, 1'b1, 2'd0, 32'd304, 32'd314);
    chk("t6_post_vld", 64'(o_valid), 64'(1));
    chk("t6_post_addr", 64'(o_write_address), 64'(0));
    chk("t6_post_fill", 64'(o_fill_count), 64'(1));
    step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
